// File: rtl/pipelined_config_multiplexer_if.sv
// Bus bundle for pipelined_config_multiplexer: data path plus serial config chain.
// config_lock exists only when PIPELINED_MUX_CONFIG_LOCK_EN is defined.
interface pipelined_config_multiplexer_if #(
    parameter int unsigned SEL_WIDTH = 3
) ();
    localparam int unsigned N = 2 ** SEL_WIDTH;

    logic [N-1:0] data_in;
    logic         data_valid_in;
    logic         data_out;
    logic         data_valid_out;
    logic         config_in;
    logic         config_enable;
    logic         config_commit;
`ifdef PIPELINED_MUX_CONFIG_LOCK_EN
    logic         config_lock;
`endif
    logic         config_out;

    modport master (
        output data_in, data_valid_in, config_in, config_enable, config_commit,
`ifdef PIPELINED_MUX_CONFIG_LOCK_EN
        output config_lock,
`endif
        input  data_out, data_valid_out, config_out
    );

    modport slave (
        input  data_in, data_valid_in, config_in, config_enable, config_commit,
`ifdef PIPELINED_MUX_CONFIG_LOCK_EN
        input  config_lock,
`endif
        output data_out, data_valid_out, config_out
    );
endinterface

// File: rtl/pipelined_config_multiplexer.sv
// 2**SEL_WIDTH:1 routing mux with scan-loaded, atomically committed selector and optional
// per-level pipelining. Optional config lock: PIPELINED_MUX_CONFIG_LOCK_EN.
module pipelined_config_multiplexer #(
    parameter int unsigned SEL_WIDTH = 3,
    parameter int unsigned PIPELINE  = 1
) (
    input logic                            i_clock,
    input logic                            i_nreset,
    pipelined_config_multiplexer_if.slave  io_bus
);
    localparam int unsigned N = 2 ** SEL_WIDTH;

    logic [SEL_WIDTH-1:0] r_shift;
    logic [SEL_WIDTH-1:0] r_selector;
    logic                 w_shift_en;
    logic                 w_commit_en;

`ifdef PIPELINED_MUX_CONFIG_LOCK_EN
    assign w_shift_en  = io_bus.config_enable & ~io_bus.config_lock;
    assign w_commit_en = io_bus.config_commit & ~io_bus.config_lock;
`else
    assign w_shift_en  = io_bus.config_enable;
    assign w_commit_en = io_bus.config_commit;
`endif

    // Commit samples the pre-shift chain contents when both happen in one cycle.
    always_ff @(posedge i_clock or negedge i_nreset) begin
        if (!i_nreset) begin
            r_shift    <= '0;
            r_selector <= '0;
        end else begin
            if (w_shift_en) begin
                r_shift <= SEL_WIDTH'({io_bus.config_in, r_shift} >> 1);
            end
            if (w_commit_en) begin
                r_selector <= r_shift;
            end
        end
    end

    assign io_bus.config_out = r_shift[0];

    if (PIPELINE != 0) begin : g_pipe
        logic [N-1:0]         r_data     [SEL_WIDTH];
        logic [SEL_WIDTH-1:0] r_sel      [SEL_WIDTH];
        logic [SEL_WIDTH-1:0] r_vld;
        logic [N-1:0]         w_src_data [SEL_WIDTH];
        logic [SEL_WIDTH-1:0] w_src_sel  [SEL_WIDTH];
        logic [SEL_WIDTH-1:0] w_src_vld;
        logic [N-1:0]         w_data_nxt [SEL_WIDTH];
        logic [SEL_WIDTH-1:0] w_sel_nxt  [SEL_WIDTH];

        // Each level keeps the surviving half in the low bits and consumes the selector MSB;
        // the carried selector shifts left so the next level again looks at its MSB.
        always_comb begin
            w_src_data[0] = io_bus.data_in;
            w_src_sel[0]  = r_selector;
            w_src_vld[0]  = io_bus.data_valid_in;
            for (int k = 1; k < SEL_WIDTH; k++) begin
                w_src_data[k] = r_data[k-1];
                w_src_sel[k]  = r_sel[k-1];
                w_src_vld[k]  = r_vld[k-1];
            end
            for (int k = 0; k < SEL_WIDTH; k++) begin
                w_data_nxt[k] = w_src_sel[k][SEL_WIDTH-1] ? (w_src_data[k] >> (N >> (k + 1)))
                                                          : w_src_data[k];
                w_sel_nxt[k]  = w_src_sel[k] << 1;
            end
        end

        always_ff @(posedge i_clock or negedge i_nreset) begin
            if (!i_nreset) begin
                for (int k = 0; k < SEL_WIDTH; k++) begin
                    r_data[k] <= '0;
                    r_sel[k]  <= '0;
                end
                r_vld <= '0;
            end else begin
                for (int k = 0; k < SEL_WIDTH; k++) begin
                    r_data[k] <= w_data_nxt[k];
                    r_sel[k]  <= w_sel_nxt[k];
                end
                r_vld <= w_src_vld;
            end
        end

        assign io_bus.data_out       = r_data[SEL_WIDTH-1][0];
        assign io_bus.data_valid_out = r_vld[SEL_WIDTH-1];
    end else begin : g_comb
        assign io_bus.data_out       = io_bus.data_in[r_selector];
        assign io_bus.data_valid_out = io_bus.data_valid_in;
    end
endmodule
